// File: rtl/memx_pkg.sv
// Shared types and MemX geometry for the MemX burst controller.
// MemX is two 256x32 halves addressed together, giving one 64-bit word per address.
package memx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } memx_state_e;

    localparam int MEMX_AW     = 8;
    localparam int MEMX_DW     = 64;
    localparam int MEMX_HW     = 32;
    localparam int MEMX_MAXLEN = 256;
    localparam int MEMX_LW     = $clog2(MEMX_MAXLEN + 1);

endpackage

// File: rtl/memx_rd_fifo.sv
// Synchronous read-return FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module memx_rd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= push_data;
    end

    // No bypass: the head is only visible once it has been written.
    assign pop_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/memx_burst_ctrl.sv
// Burst read/write controller driving the MemX pins; read data returns through
// a credit-limited FIFO so back-pressure on the read stream never overflows it.
module memx_burst_ctrl
    import memx_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int RDQ_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [MEMX_AW-1:0] cmd_addr,
    input  logic [MEMX_LW-1:0] cmd_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [MEMX_DW-1:0] wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [MEMX_DW-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic [MEMX_AW-1:0] common_address,
    output logic [MEMX_HW-1:0] Product,
    output logic [MEMX_HW-1:0] C,
    output logic               WrtEnbX,
    output logic               notWrtEnbX,
    input  logic [MEMX_DW-1:0] memX_dataout
);

    localparam int CW = $clog2(RDQ_DEPTH + 1);
    localparam int SW = CW + 1;

    memx_state_e        state;
    logic [MEMX_AW-1:0] addr;
    logic [MEMX_LW-1:0] remaining;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      fifo_count;
    logic [RD_LAT-1:0]  rd_vld_p;
    logic [SW-1:0]      credit_used;
    logic               done_q;
    logic               done_pend;
    logic               push;
    logic               pop;
    logic               wr_beat;
    logic               issue;
    logic               drain_done;

    assign push        = rd_vld_p[RD_LAT-1];
    assign rd_valid    = (fifo_count != '0);
    assign pop         = rd_valid && rd_ready;
    assign wr_beat     = wr_valid && wr_ready;
    assign credit_used = SW'(fifo_count) + SW'(outstanding);
    assign issue       = (state == READ) && (credit_used < SW'(RDQ_DEPTH));
    assign busy        = (state != IDLE);

    // The final read handshake is only known from rd_ready, so the drain
    // completion pulse is combined with the registered pulse here.
    assign drain_done = (state == DRAIN) && (outstanding == '0) &&
                        (fifo_count == CW'(1)) && rd_ready;
    assign done       = done_q || drain_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            wr_ready       <= 1'b0;
            done_q         <= 1'b0;
            done_pend      <= 1'b0;
            addr           <= '0;
            remaining      <= '0;
            outstanding    <= '0;
            rd_vld_p       <= '0;
            common_address <= '0;
            Product        <= '0;
            C              <= '0;
            WrtEnbX        <= 1'b0;
            notWrtEnbX     <= 1'b0;
        end else begin
            WrtEnbX    <= 1'b0;
            notWrtEnbX <= 1'b0;
            done_q     <= done_pend;
            done_pend  <= 1'b0;

            // Capture timing: one stage per cycle of MemX read latency.
            rd_vld_p[0] <= notWrtEnbX;
            for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
            outstanding <= outstanding + CW'(issue) - CW'(push);

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else if (cmd_write) begin
                            state     <= WRITE;
                            cmd_ready <= 1'b0;
                            wr_ready  <= 1'b1;
                        end else begin
                            state     <= READ;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        WrtEnbX        <= 1'b1;
                        common_address <= addr;
                        Product        <= wr_data[MEMX_DW-1:MEMX_HW];
                        C              <= wr_data[MEMX_HW-1:0];
                        addr           <= addr + 1'b1;
                        remaining      <= remaining - 1'b1;
                        if (remaining == MEMX_LW'(1)) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            wr_ready  <= 1'b0;
                            done_pend <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        notWrtEnbX     <= 1'b1;
                        common_address <= addr;
                        addr           <= addr + 1'b1;
                        remaining      <= remaining - 1'b1;
                        if (remaining == MEMX_LW'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    memx_rd_fifo #(
        .DEPTH  (RDQ_DEPTH),
        .DATA_W (MEMX_DW)
    ) u_rd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (memX_dataout),
        .pop       (pop),
        .pop_data  (rd_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_memx_burst_ctrl.sv
// Directed bench for memx_burst_ctrl: cycle-vector table for write bursts plus
// scripted read, wrap, back-pressure and mid-burst reset sequences.
module tb_memx_burst_ctrl;

    localparam int RDQ = 4;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        busy;
    logic        done;
    logic [7:0]  common_address;
    logic [31:0] Product;
    logic [31:0] C;
    logic        WrtEnbX;
    logic        notWrtEnbX;
    logic [63:0] memX_dataout;

    logic [63:0] mem     [256];
    logic [63:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        cv;
        logic        cw;
        logic [7:0]  ca;
        logic [8:0]  cl;
        logic        wv;
        logic [63:0] wd;
        logic [77:0] exp;
    } vec_t;

    vec_t vt[$];

    memx_burst_ctrl #(.RD_LAT(1), .RDQ_DEPTH(RDQ)) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .common_address (common_address),
        .Product        (Product),
        .C              (C),
        .WrtEnbX        (WrtEnbX),
        .notWrtEnbX     (notWrtEnbX),
        .memX_dataout   (memX_dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MemX model: synchronous SRAM, read data valid one cycle after the sampling edge.
    always @(posedge clock) begin
        if (WrtEnbX) mem[common_address] <= {Product, C};
        if (notWrtEnbX) memX_dataout <= mem[common_address];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [77:0] obs();
        return {cmd_ready, wr_ready, busy, done, WrtEnbX, notWrtEnbX, common_address, Product, C};
    endfunction

    function automatic logic [77:0] ex(input logic cr, input logic wr, input logic bz,
                                       input logic dn, input logic we, input logic nwe,
                                       input logic [7:0] ad, input logic [31:0] p,
                                       input logic [31:0] c);
        return {cr, wr, bz, dn, we, nwe, ad, p, c};
    endfunction

    function automatic vec_t mk(input logic cv, input logic cw, input logic [7:0] ca,
                                input logic [8:0] cl, input logic wv, input logic [63:0] wd,
                                input logic [77:0] e);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd; v.exp = e;
        return v;
    endfunction

    task automatic do_write(input logic [7:0] a, input int len, input logic [63:0] d0,
                            input logic [63:0] inc);
        logic [63:0] dk;
        logic [7:0]  ea;
        int k;
        int guard;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 9'(len);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        dk = d0; wr_valid = 1'b1; wr_data = dk;
        k = 0; guard = 0;
        while (k < len && guard < 100) begin
            @(posedge clock); #1;
            if (WrtEnbX) begin
                ea = a + 8'(k);
                check("wr_addr", 80'(common_address), 80'(ea));
                check("wr_data", 80'({Product, C}), 80'(dk));
                check("wr_no_early_done", 80'(done), 80'(0));
                ref_mem[ea] = dk;
                k++;
                dk = dk + inc;
                wr_data = dk;
            end
            guard++;
        end
        wr_valid = 1'b0;
        check("wr_beats", 80'(k), 80'(len));
        @(posedge clock); #1;
        check("wr_done_pulse", 80'({done, WrtEnbX, cmd_ready}), 80'(3'b101));
        @(posedge clock); #1;
        check("wr_done_clear", 80'(done), 80'(0));
    endtask

    task automatic do_read(input logic [7:0] a, input int len, input int hold, input bit chk_lat);
        logic [7:0] na;
        logic [7:0] ea;
        int issued;
        int got;
        int stray;
        int t_iss;
        int t_val;
        int guard;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = 9'(len);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        na = a; issued = 0; got = 0; stray = 0; t_iss = -1; t_val = -1; guard = 0;
        while (got < len && guard < 400) begin
            rd_ready = (guard >= hold);
            #1;
            if (notWrtEnbX) begin
                if (t_iss < 0) t_iss = guard;
                check("rd_issue_addr", 80'(common_address), 80'(na));
                na = na + 8'd1;
                issued++;
                check("rd_credit", 80'(issued - got <= RDQ), 80'(1));
            end
            if (rd_valid && t_val < 0) t_val = guard;
            if (rd_valid && rd_ready) begin
                ea = a + 8'(got);
                check("rd_data", 80'(rd_data), 80'(ref_mem[ea]));
                check("rd_done", 80'(done), 80'(got == len - 1));
                got++;
            end else if (done) begin
                stray++;
            end
            if (hold > 0 && guard == hold - 1) check("rd_bp_stall", 80'(issued), 80'(RDQ));
            @(posedge clock); #1;
            guard++;
        end
        rd_ready = 1'b0;
        check("rd_beats", 80'(got), 80'(len));
        check("rd_issues", 80'(issued), 80'(len));
        check("rd_stray_done", 80'(stray), 80'(0));
        check("rd_idle", 80'({cmd_ready, busy, rd_valid}), 80'(3'b100));
        if (chk_lat) check("rd_latency", 80'(t_val - t_iss), 80'(2));
    endtask

    initial begin
        logic [63:0] d0;
        logic [63:0] di;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [63:0] e2;
        int iss;
        int guard;
        int bad;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = {32'hC0DE0000, 24'd0, 8'(i)};
            ref_mem[i] = {32'hC0DE0000, 24'd0, 8'(i)};
        end
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        d0 = 64'h00000001_00000002;
        di = 64'h00000001_00000001;
        e0 = 64'hA0A0A0A0_05050505;
        e1 = 64'hA1A1A1A1_15151515;
        e2 = 64'hA2A2A2A2_25252525;

        vt.push_back(mk(1, 1, 8'h10, 9'd4, 1, d0,        ex(0,1,1,0,0,0,8'h00,32'd0,32'd0)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, d0,        ex(0,1,1,0,1,0,8'h10,32'd1,32'd2)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, d0 + di,   ex(0,1,1,0,1,0,8'h11,32'd2,32'd3)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, d0 + 2*di, ex(0,1,1,0,1,0,8'h12,32'd3,32'd4)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, d0 + 3*di, ex(1,0,0,0,1,0,8'h13,32'd4,32'd5)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(1,0,0,1,0,0,8'h13,32'd4,32'd5)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(1,0,0,0,0,0,8'h13,32'd4,32'd5)));
        vt.push_back(mk(1, 1, 8'h20, 9'd3, 0, 64'd0,     ex(0,1,1,0,0,0,8'h13,32'd4,32'd5)));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, e0,        ex(0,1,1,0,1,0,8'h20,e0[63:32],e0[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(0,1,1,0,0,0,8'h20,e0[63:32],e0[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, e1,        ex(0,1,1,0,1,0,8'h21,e1[63:32],e1[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(0,1,1,0,0,0,8'h21,e1[63:32],e1[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 1, e2,        ex(1,0,0,0,1,0,8'h22,e2[63:32],e2[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(1,0,0,1,0,0,8'h22,e2[63:32],e2[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(1,0,0,0,0,0,8'h22,e2[63:32],e2[31:0])));
        vt.push_back(mk(1, 1, 8'h30, 9'd0, 0, 64'd0,     ex(1,0,0,1,0,0,8'h22,e2[63:32],e2[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(1,0,0,0,0,0,8'h22,e2[63:32],e2[31:0])));
        vt.push_back(mk(1, 0, 8'h40, 9'd0, 0, 64'd0,     ex(1,0,0,1,0,0,8'h22,e2[63:32],e2[31:0])));
        vt.push_back(mk(0, 0, 8'h00, 9'd0, 0, 64'd0,     ex(1,0,0,0,0,0,8'h22,e2[63:32],e2[31:0])));

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_state", 80'(obs()), 80'(ex(1,0,0,0,0,0,8'h00,32'd0,32'd0)));
        check("reset_rd", 80'({rd_valid, rd_data}), 80'(0));

        foreach (vt[i]) begin
            cmd_valid = vt[i].cv; cmd_write = vt[i].cw; cmd_addr = vt[i].ca; cmd_len = vt[i].cl;
            wr_valid = vt[i].wv; wr_data = vt[i].wd;
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), 80'(obs()), 80'(vt[i].exp));
        end
        cmd_valid = 1'b0; wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) ref_mem[8'h10 + k] = d0 + 64'(k) * di;
        ref_mem[8'h20] = e0;
        ref_mem[8'h21] = e1;
        ref_mem[8'h22] = e2;

        do_read(8'h10, 4, 0, 1'b1);
        do_read(8'h20, 3, 0, 1'b0);

        do_write(8'hFE, 4, 64'h000000FE_10000000, 64'h00000001_00000001);
        check("wrap_mem00", 80'(ref_mem[8'h00]), 80'(64'h00000100_10000002));
        do_read(8'hFE, 4, 0, 1'b0);

        do_read(8'h10, 16, 20, 1'b0);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 9'd8; rd_ready = 1'b0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        iss = 0; guard = 0;
        while (iss < 3 && guard < 50) begin
            @(posedge clock); #1;
            if (notWrtEnbX) iss++;
            guard++;
        end
        check("mid_issues", 80'(iss), 80'(3));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_reset_state", 80'(obs()), 80'(ex(1,0,0,0,0,0,8'h00,32'd0,32'd0)));
        check("mid_reset_fifo", 80'({rd_valid, rd_data}), 80'(0));
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (done || notWrtEnbX || rd_valid || busy) bad++;
        end
        check("mid_reset_quiet", 80'(bad), 80'(0));
        do_read(8'h20, 1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
